// File: rtl/fifo_wr_arbiter.sv
// Four-requester arbiter granting bursts of up to BURST_LEN writes into a shared FIFO.
// Define ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              fifo_full,
  output logic [3:0]        ack,
  output logic [3:0]        grant,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              busy
);

  // Handshake: requester i raises req[i] and holds din stable; a word is
  // transferred in every cycle where req[i] & ack[i] are both high. ack is
  // combinational and never asserts while fifo_full is high or rst is high.

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

  state_t     state;
  logic [1:0] owner;
  logic [3:0] count;
  logic [1:0] winner;
  logic       wr;
  logic       last_wr;

`ifndef ARB_FIXED_PRI_EN
  logic [1:0] rr_ptr;

  // Scan from the farthest offset down so the nearest set bit above rr_ptr wins.
  always_comb begin
    winner = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) winner = rr_ptr + 2'(k);
    end
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) winner = 2'(k);
    end
  end
`endif

  assign wr      = (state == BURST) && req[owner] && !fifo_full && !rst;
  assign last_wr = wr && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      count <= 4'd0;
`ifndef ARB_FIXED_PRI_EN
      rr_ptr <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= winner;
            count <= 4'd0;
            state <= BURST;
          end
        end
        BURST: begin
          if (!req[owner] || last_wr) begin
            state <= IDLE;
`ifndef ARB_FIXED_PRI_EN
            rr_ptr <= owner + 2'd1;
`endif
          end else if (wr) begin
            count <= count + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    grant      = 4'b0000;
    ack        = 4'b0000;
    fifo_wr_en = wr;
    busy       = (state == BURST);
    fifo_din   = '0;
    if (state == BURST) begin
      grant = 4'b0001 << owner;
      case (owner)
        2'd0:    fifo_din = din0;
        2'd1:    fifo_din = din1;
        2'd2:    fifo_din = din2;
        default: fifo_din = din3;
      endcase
    end
    if (wr) ack = 4'b0001 << owner;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then random traffic, all checked
// each cycle against a burst-level model of owner, writes done and next-preferred requester.
module tb_fifo_wr_arbiter;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req;
  logic [DATA_W-1:0] din [4];
  logic              fifo_full;
  logic [3:0]        ack;
  logic [3:0]        grant;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_din;
  logic              busy;

  fifo_wr_arbiter #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .fifo_full(fifo_full), .ack(ack), .grant(grant),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  int m_owner = -1;   // -1 when nobody holds the FIFO port
  int m_done  = 0;    // writes accepted in the current burst
  int m_next  = 0;    // requester preferred at the next arbitration

  logic [3:0] seen_grant;
  logic       seen_wr;
  logic       seen_busy;
  logic [3:0] prev_req = 4'b0000;
  logic [3:0] prev_ack = 4'b0000;
  bit         din_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic onehot0(input logic [3:0] v);
    return (v & (v - 4'd1)) == 4'd0;
  endfunction

  // One clock cycle: apply inputs, check outputs at negedge, advance the model.
  task automatic step(input logic [3:0] r, input logic f, input logic rs);
    logic [3:0]        e_grant;
    logic [3:0]        e_ack;
    logic              e_wr;
    logic [DATA_W-1:0] e_din;
    int                w;
    if (din_rand) begin
      for (int i = 0; i < 4; i++)
        if (!prev_req[i] || prev_ack[i]) din[i] = DATA_W'($urandom);
    end
    req = r; fifo_full = f; rst = rs;
    @(negedge clk);
    e_grant = 4'b0000; e_ack = 4'b0000; e_wr = 1'b0; e_din = '0;
    if (m_owner >= 0) begin
      e_grant = 4'b0001 << m_owner;
      e_din   = din[m_owner];
      e_wr    = r[m_owner] && !f && !rs;
      if (e_wr) e_ack = e_grant;
    end
    chk("grant", 32'(grant), 32'(e_grant));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    chk("fifo_din", 32'(fifo_din), 32'(e_din));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("wr_vs_full", 32'(fifo_wr_en && fifo_full), 32'd0);
    chk("ack_eq_grant_wr", 32'(ack), 32'(grant & {4{fifo_wr_en}}));
    chk("onehot", 32'(onehot0(grant) && onehot0(ack)), 32'd1);
    seen_grant = grant; seen_wr = fifo_wr_en; seen_busy = busy;
    prev_req = r; prev_ack = e_ack;
    @(posedge clk);
    if (rs) begin
      m_owner = -1; m_done = 0; m_next = 0;
    end else if (m_owner < 0) begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (w < 0 && r[(m_next + i) % 4]) w = (m_next + i) % 4;
      if (w >= 0) begin m_owner = w; m_done = 0; end
    end else begin
      if (e_wr) m_done++;
      if (!r[m_owner] || m_done == BURST_LEN) begin
`ifndef ARB_FIXED_PRI_EN
        m_next = (m_owner + 1) % 4;
`endif
        m_owner = -1;
      end
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] owners[$];
    logic [3:0] prev_g;
    logic [3:0] exp_o;
    logic [3:0] r;
    int n;

    for (int i = 0; i < 4; i++) din[i] = DATA_W'(8'h10 * (i + 1));
    req = 4'b0000; fifo_full = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Reset state
    step(4'b0000, 1'b0, 1'b1);
    chk("reset_grant", 32'(seen_grant), 32'd0);

    // Single requester, held six cycles: four writes of A5, idle, new burst
    din[0] = 8'hA5;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (c == 1) chk("first_write_latency", 32'(seen_wr), 32'd1);
      if (c == 5) chk("idle_after_burst", 32'(seen_busy), 32'd0);
      n += int'(seen_wr);
    end
    chk("burst_write_count", 32'(n), 32'd4);
    step(4'b0001, 1'b0, 1'b0);
    chk("rearm_grant", 32'(seen_grant), 32'b0001);

    // All requesters: grant order across five bursts
    step(4'b0000, 1'b0, 1'b1);
    prev_g = 4'b0000;
    for (int c = 0; c < 25; c++) begin
      step(4'b1111, 1'b0, 1'b0);
      if (seen_grant != 4'b0000 && prev_g == 4'b0000) owners.push_back(seen_grant);
      prev_g = seen_grant;
    end
    chk("burst_starts", 32'(owners.size()), 32'd5);
    for (int i = 0; i < 5 && i < owners.size(); i++) begin
`ifndef ARB_FIXED_PRI_EN
      exp_o = 4'b0001 << (i % 4);
`else
      exp_o = 4'b0001;
`endif
      chk("rr_order", 32'(owners[i]), 32'(exp_o));
    end

    // Full stall mid-burst after two writes
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(4'b0001, 1'b1, 1'b0);
      chk("stall_no_write", 32'(seen_wr), 32'd0);
      chk("stall_grant_held", 32'(seen_grant), 32'b0001);
    end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (!seen_busy) break;
      n += int'(seen_wr);
    end
    chk("writes_after_stall", 32'(n), 32'd2);

    // Owner drops req after one write; requester 2 waits
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    chk("drop_no_write", 32'(seen_wr), 32'd0);
    step(4'b0100, 1'b0, 1'b0);
    chk("drop_idle", 32'(seen_busy), 32'd0);
    step(4'b0100, 1'b0, 1'b0);
    chk("drop_next_owner", 32'(seen_grant), 32'b0100);

    // Reset during a burst
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    chk("rst_no_write", 32'(seen_wr), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("post_rst_idle", 32'({seen_grant, seen_busy}), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("post_rst_grant", 32'(seen_grant), 32'b0001);

    // Random traffic: requests persist, occasional full and reset
    din_rand = 1'b1;
    r = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
      step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, width of each requester data word and of FIFO write data.
REQ-002 Parameter: BURST_LEN, default 4, maximum accepted writes per grant; legal range 1..16.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 Port: din0, din1, din2, din3  input  DATA_W each  requester data words.
REQ-007 Port: fifo_full  input  1  full flag from the shared FIFO.
REQ-008 Port: ack  output  4  one-hot; bit i high means requester i's word is written this cycle.
REQ-009 Port: grant  output  4  one-hot owner of the FIFO write port; all zero when idle.
REQ-010 Port: fifo_wr_en  output  1  FIFO write enable.
REQ-011 Port: fifo_din  output  DATA_W  FIFO write data.
REQ-012 Port: busy  output  1  high while a burst is in progress.

Function
REQ-013 FSM has exactly two states, IDLE and BURST; registers are state, owner (2 bits), rr pointer (2 bits) and burst count (4 bits).
REQ-014 IDLE: grant, ack, fifo_wr_en and busy are 0; fifo_din is 0.
REQ-015 IDLE with any req bit set: winner is the first set bit searching upward from rr pointer with wrap 3->0; owner <= winner, count <= 0, state <= BURST.
REQ-016 Arbitration latency is one cycle: first possible write is the cycle after the winning req is sampled in IDLE.
REQ-017 BURST: grant[owner] = 1, busy = 1, fifo_din = din of owner, combinationally.
REQ-018 BURST write condition: req[owner] & ~fifo_full; when true, ack[owner] = 1, fifo_wr_en = 1 the same cycle, count increments.
REQ-019 fifo_wr_en shall never be asserted while fifo_full is high; a full stall holds state, owner and count unchanged indefinitely.
REQ-020 Burst ends (state <= IDLE, rr pointer <= owner+1 mod 4) when a write occurs with count == BURST_LEN-1, or when req[owner] is low in BURST.
REQ-021 Requesters not owning the port receive ack = 0 and grant = 0 regardless of their req.
REQ-022 A requester whose req is high in the IDLE cycle after its own burst ended is eligible, but the rr pointer has moved past it, so other waiting requesters win first.
REQ-023 At most one ack bit and at most one grant bit are high in any cycle.
REQ-024 Requesters shall hold din stable while req is high and ack is low; the block never registers data.

Reset
REQ-025 While rst is high at a rising edge: state <= IDLE, owner <= 0, rr pointer <= 0, count <= 0.
REQ-026 Outputs in the cycle after reset equal the IDLE values of REQ-014; no write occurs during a cycle in which rst is high.
REQ-027 Reset during BURST aborts the burst; unacknowledged words are not written and the first post-reset grant follows REQ-015 with pointer 0.

Configuration
REQ-028 Macro ARB_FIXED_PRI_EN: when defined, the IDLE winner is the lowest-index set req bit and the rr pointer is not implemented.
REQ-029 When ARB_FIXED_PRI_EN is undefined, round-robin arbitration of REQ-015 and REQ-020 applies; all other behaviour is identical in both builds.

Verification
REQ-030 Reset then req=4'b0001, din0=8'hA5 held 6 cycles, fifo_full=0 -> grant=0001 one cycle after req, 4 consecutive ack/fifo_wr_en pulses with fifo_din=A5, one IDLE cycle, then new burst.
REQ-031 req=4'b1111 held, fifo_full=0, round-robin build -> bursts of 4 writes granted in order 0,1,2,3,0; fixed-priority build -> owner always 0.
REQ-032 Mid-burst after 2 writes assert fifo_full for 3 cycles -> fifo_wr_en=0, ack=0, grant held; after release exactly 2 more writes, then IDLE.
REQ-033 Owner drops req after 1 write while req[2] is high -> IDLE next cycle, requester 2 granted the following cycle, pointer = owner+1.
REQ-034 Assert rst for one cycle during BURST with pending req -> no write in that cycle, IDLE outputs next cycle, re-arbitration from pointer 0.
REQ-035 Every cycle check: fifo_wr_en implies ~fifo_full, ack == grant & {4{fifo_wr_en}}, grant and ack are one-hot or zero.
